// File: rtl/div_clk_monitor.sv
// Receive-side checker for an even divided clock. Measures the period and high time
// of div_in in clk_in cycles, locks on a stable 50%-duty ratio and flags errors or a stall.
module div_clk_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_in,
  output logic [CNT_W-1:0] ratio,
  output logic [CNT_W-1:0] high_time,
  output logic             ratio_vld,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam int               MW      = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_CNT);
  localparam logic [MW-1:0]    MATCH_1 = MW'(1);

  typedef enum logic {SEEK, MEAS} state_t;

  state_t           state_q;
  logic             d_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] prev_q;
  logic [CNT_W-1:0] ratio_q;
  logic [CNT_W-1:0] high_q;
  logic [MW-1:0]    match_q;
  logic             vld_q;
  logic             locked_q;
  logic             err_q;
  logic             timeout_q;

  logic             rise;
  logic             duty_ok;
  logic             good;
  logic [MW-1:0]    match_d;

  // Classify the period that ends on the current rise; a duty-correct period of a new
  // length restarts the streak at one instead of zero.
  always_comb begin
    rise    = div_in & ~d_q;
    duty_ok = ~cnt_q[0] && (hcnt_q == (cnt_q >> 1));
    good    = duty_ok && ((match_q == '0) || (cnt_q == prev_q));
    if (good) begin
      match_d = (match_q >= LOCK_V) ? LOCK_V : match_q + 1'b1;
    end else if (duty_ok) begin
      match_d = MATCH_1;
    end else begin
      match_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= SEEK;
      d_q       <= 1'b0;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      prev_q    <= '0;
      ratio_q   <= '0;
      high_q    <= '0;
      match_q   <= '0;
      vld_q     <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      d_q       <= div_in;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        SEEK: begin
          if (rise) begin
            cnt_q   <= CNT_ONE;
            hcnt_q  <= CNT_ONE;
            state_q <= MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            ratio_q <= cnt_q;
            high_q  <= hcnt_q;
            vld_q   <= 1'b1;
            prev_q  <= cnt_q;
            match_q <= match_d;
            cnt_q   <= CNT_ONE;
            hcnt_q  <= CNT_ONE;
            if (good) begin
              if (match_d == LOCK_V) begin
                locked_q <= 1'b1;
              end
            end else begin
              locked_q <= 1'b0;
              err_q    <= locked_q;
            end
          end else if (cnt_q == CNT_MAX) begin
            // Stall guard: give up on this edge before the counter could wrap.
            timeout_q <= 1'b1;
            locked_q  <= 1'b0;
            match_q   <= '0;
            state_q   <= SEEK;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            hcnt_q <= hcnt_q + CNT_W'(div_in);
          end
        end
        default: state_q <= SEEK;
      endcase
    end
  end

  assign ratio     = ratio_q;
  assign high_time = high_q;
  assign ratio_vld = vld_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign timeout   = timeout_q;

endmodule
